vx_sau_matmul: RTL and testbench

//  Parametrised output-stationary systolic matrix-multiply engine for the SAU path in VX_execute.

---
 rtl/vx_sau_matmul.sv | 179 +++++++++++++++++
 tb/tb_vx_sau_matmul.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_sau_matmul.sv
// Output-stationary NxN systolic matrix-multiply engine: streams K outer-product beats
// (A column, B row) through skewed inputs into a MAC grid and drains C one row per beat.
module vx_sau_matmul #(
  parameter int unsigned MATRIX_SIZE = 4,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned ACC_SIZE    = 2 * DATA_SIZE
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0]    req_a,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0]    req_b,
  input  logic                                req_last,
  input  logic                                req_acc,
  input  logic                                req_signed,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(MATRIX_SIZE)-1:0]      rsp_row,
  output logic [MATRIX_SIZE*ACC_SIZE-1:0]     rsp_data,
  output logic                                busy
);

  localparam int unsigned N    = MATRIX_SIZE;
  localparam int unsigned RowW = $clog2(N);
  localparam int unsigned CntW = $clog2(2 * N);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StOutput} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              signed_q, signed_d;
  logic              req_fire, rsp_fire, clr_acc;

  logic [DATA_SIZE-1:0] a_in   [N][N];
  logic [DATA_SIZE-1:0] b_in   [N][N];
  logic [ACC_SIZE-1:0]  acc_arr[N][N];

  assign req_ready = (state_q == StIdle) || (state_q == StLoad);
  assign rsp_valid = (state_q == StOutput);
  assign busy      = (state_q != StIdle);
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  // Nothing is in flight in IDLE, so clearing on the first accepted beat loses no products.
  assign clr_acc   = (state_q == StIdle) && req_fire && !req_acc;
  assign rsp_row   = row_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    signed_d = signed_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          signed_d = req_signed;
          if (req_last) begin
            state_d = StDrain;
            cnt_d   = CntW'(2 * N - 2);
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (req_fire && req_last) begin
          state_d = StDrain;
          cnt_d   = CntW'(2 * N - 2);
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StOutput;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StOutput: begin
        if (rsp_fire) begin
          if (row_q == RowW'(N - 1)) begin
            state_d = StIdle;
            row_d   = '0;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      row_q    <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      signed_q <= signed_d;
    end
  end

  // Input skew: row i of A and column i of B pass through i+1 registers before the grid edge.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_SIZE-1:0] sa_q [i+1];
    logic [DATA_SIZE-1:0] sb_q [i+1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s <= i; s++) begin
          sa_q[s] <= '0;
          sb_q[s] <= '0;
        end
      end else begin
        sa_q[0] <= req_fire ? req_a[i*DATA_SIZE +: DATA_SIZE] : '0;
        sb_q[0] <= req_fire ? req_b[i*DATA_SIZE +: DATA_SIZE] : '0;
        for (int s = 1; s <= i; s++) begin
          sa_q[s] <= sa_q[s-1];
          sb_q[s] <= sb_q[s-1];
        end
      end
    end

    assign a_in[i][0] = sa_q[i];
    assign b_in[0][i] = sb_q[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [ACC_SIZE-1:0] acc_q, acc_d, a_ext, b_ext;

      always_comb begin
        a_ext = signed_q ? {{(ACC_SIZE-DATA_SIZE){a_in[i][j][DATA_SIZE-1]}}, a_in[i][j]}
                         : {{(ACC_SIZE-DATA_SIZE){1'b0}}, a_in[i][j]};
        b_ext = signed_q ? {{(ACC_SIZE-DATA_SIZE){b_in[i][j][DATA_SIZE-1]}}, b_in[i][j]}
                         : {{(ACC_SIZE-DATA_SIZE){1'b0}}, b_in[i][j]};
        acc_d = clr_acc ? '0 : acc_q + a_ext * b_ext;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
      end

      assign acc_arr[i][j] = acc_q;

      if (j < N - 1) begin : g_a_fwd
        logic [DATA_SIZE-1:0] a_q;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) a_q <= '0;
          else       a_q <= a_in[i][j];
        end
        assign a_in[i][j+1] = a_q;
      end

      if (i < N - 1) begin : g_b_fwd
        logic [DATA_SIZE-1:0] b_q;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) b_q <= '0;
          else       b_q <= b_in[i][j];
        end
        assign b_in[i+1][j] = b_q;
      end
    end
  end

  always_comb begin
    rsp_data = '0;
    for (int j = 0; j < N; j++) begin
      rsp_data[j*ACC_SIZE +: ACC_SIZE] = acc_arr[row_q][j];
    end
  end

endmodule

// File: tb/tb_vx_sau_matmul.sv
// Scoreboard bench for vx_sau_matmul: a C model fills an expected-row queue per job and a
// response monitor pops it on every row handshake.
module tb_vx_sau_matmul;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int AW   = 64;
  localparam int KMAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_last, req_acc, req_signed;
  logic [N*DW-1:0]   req_a, req_b;
  logic              rsp_valid, rsp_ready, busy;
  logic [1:0]        rsp_row;
  logic [N*AW-1:0]   rsp_data;

  typedef struct {
    int              row;
    logic [N*AW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] ma [N][KMAX];
  logic [DW-1:0] mb [KMAX][N];
  logic [AW-1:0] cm [N][N];

  vx_sau_matmul #(.MATRIX_SIZE(N), .DATA_SIZE(DW), .ACC_SIZE(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_last  (req_last),
    .req_acc   (req_acc),
    .req_signed(req_signed),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_row   (rsp_row),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return AW'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic clear_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        ma[i][k] = '0;
        mb[k][i] = '0;
      end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) cm[i][j] = '0;
  endtask

  task automatic monitor_rsp();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got row %0d data %0h, required no response",
                   rsp_row, rsp_data);
        end else begin
          e = exp_q.pop_front();
          if (rsp_row !== 2'(e.row) || rsp_data !== e.data) begin
            errors++;
            $display("FAIL rsp_row%0d: got row %0d data %0h, required row %0d data %0h",
                     e.row, rsp_row, rsp_data, e.row, e.data);
          end
        end
      end
    end
  endtask

  task automatic send_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                           input logic last, input logic acc, input logic sgn);
    int n = 0;
    req_valid = 1'b1; req_a = a; req_b = b;
    req_last = last; req_acc = acc; req_signed = sgn;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL beat_accept: got req_ready 0 for %0d cycles, required 1", n);
    end
    tick();
    req_valid = 1'b0; req_a = '0; req_b = '0; req_last = 1'b0;
  endtask

  // Updates the model, queues expected rows, then drives the beats; returns just after the
  // last beat's accepting edge. Non-first beats carry inverted acc/signed, which must be ignored.
  task automatic do_job(input int k_len, input logic acc, input logic sgn, input int gap);
    logic [N*DW-1:0] a, b;
    exp_t e;
    if (!acc) clear_model();
    for (int k = 0; k < k_len; k++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) cm[i][j] = cm[i][j] + mul(ma[i][k], mb[k][j], sgn);
    for (int r = 0; r < N; r++) begin
      e.row = r;
      for (int j = 0; j < N; j++) e.data[j*AW +: AW] = cm[r][j];
      exp_q.push_back(e);
    end
    for (int k = 0; k < k_len; k++) begin
      for (int i = 0; i < N; i++) begin
        a[i*DW +: DW] = ma[i][k];
        b[i*DW +: DW] = mb[k][i];
      end
      send_beat(a, b, k == k_len - 1, (k == 0) ? acc : ~acc, (k == 0) ? sgn : ~sgn);
      if (k != k_len - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_done: got busy %0b pending rows %0d, required 0 and 0",
               name, busy, exp_q.size());
    end
  endtask

  task automatic check_drain(input string name);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2 * N - 1) begin
      errors++;
      $display("FAIL %s_drain: got %0d cycles to rsp_valid, required %0d", name, n, 2 * N - 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    req_last = 1'b0; req_acc = 1'b0; req_signed = 1'b0; rsp_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks += 4;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    if (rsp_row !== 2'd0) begin errors++; $display("FAIL rst_rsp_row: got %0d required 0", rsp_row); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
  endtask

  task automatic test_basic();
    clear_mats();
    ma[0][0] = 1; ma[1][1] = 1;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    do_job(2, 1'b0, 1'b0, 0);
    check_drain("basic");
    wait_idle("basic");
  endtask

  task automatic test_random_gaps();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        ma[i][k] = $urandom();
        mb[k][i] = $urandom();
      end
    do_job(3, 1'b0, 1'b0, 2);
    check_drain("gaps");
    wait_idle("gaps");
  endtask

  task automatic test_accumulate();
    clear_mats();
    for (int i = 0; i < N; i++) begin
      ma[i][i] = 1;
      mb[i][i] = 1;
    end
    do_job(N, 1'b0, 1'b0, 0);
    wait_idle("acc_job1");
    do_job(N, 1'b1, 1'b0, 1);
    wait_idle("acc_job2");
  endtask

  task automatic test_signed_one(input logic sgn, input logic [AW-1:0] want);
    int n = 0;
    rsp_ready = 1'b0;
    do_job(1, 1'b0, sgn, 0);
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_data[AW-1:0] !== want) begin
      errors++;
      $display("FAIL c00_signed%0b: got %h required %h", sgn, rsp_data[AW-1:0], want);
    end
    rsp_ready = 1'b1;
    wait_idle("signed");
  endtask

  task automatic test_signed();
    clear_mats();
    for (int i = 1; i < N; i++) begin
      ma[i][0] = $urandom();
      mb[0][i] = $urandom();
    end
    ma[0][0] = 32'hFFFF_FFFD;
    mb[0][0] = 32'd4;
    test_signed_one(1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
    test_signed_one(1'b0, 64'h0000_0003_FFFF_FFF4);
  endtask

  task automatic test_stall();
    int n = 0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) begin
        ma[i][k] = $urandom();
        mb[k][i] = $urandom();
      end
    rsp_ready = 1'b0;
    do_job(2, 1'b0, 1'b1, 0);
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_row !== 2'd0 || rsp_data !== exp_q[0].data) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid %b row %0d data %h, required 1 0 %h",
                 c, rsp_valid, rsp_row, rsp_data, exp_q[0].data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_busy_hold: got %b required 1", busy);
      end
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_busy_drop: got busy %b valid %b, required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) begin
        ma[i][k] = $urandom();
        mb[k][i] = $urandom();
      end
    do_job(2, 1'b0, 1'b0, 0);
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", rsp_valid); end
    exp_q.delete();
    clear_model();
    tick();
    reset = 1'b0;
    tick();
    do_job(2, 1'b1, 1'b0, 0);
    wait_idle("midrst_next");
  endtask

  initial begin
    fork
      monitor_rsp();
    join_none
    test_reset();
    test_basic();
    test_random_gaps();
    test_accumulate();
    test_signed();
    test_stall();
    test_reset_mid();
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
